// File: rtl/angle_norm_pkg.sv
// Shared definitions for the angle normalisation sequencer.
// - state_t      : sequencer state encoding
// - word_width   : float word width from exponent and mantissa widths
// - addr_width   : index width for a memory of the given depth
// - count_width  : width able to hold 0..depth inclusive
package angle_norm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  function automatic int word_width(input int exp_len, input int mantissa_len);
    return exp_len + mantissa_len + 1;
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/angle_norm_timeout.sv
// Wait-for-normalizer watchdog: a down-counter with terminal-count compare.
// Ports:
//   clock, reset_n : clock and synchronous active-low reset
//   load           : preload the counter with TIMEOUT_CYCLES
//   enable         : count down one step per cycle (one waiting cycle)
//   expired        : high in the TIMEOUT_CYCLES-th enabled cycle after load
module angle_norm_timeout #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] remaining;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= TW'(TIMEOUT_CYCLES);
    end else if (enable && remaining != '0) begin
      remaining <= remaining - 1'b1;
    end
  end

  // Terminal count is 1, so the expiring cycle is itself the last waiting cycle.
  assign expired = enable && (remaining <= TW'(1));

endmodule

// File: rtl/angle_norm_sequencer.sv
// Walks a block of float angles in an external memory, passes each one through
// an external normalizer and writes the result back to the same index.
// Ports:
//   clock, reset_n          : clock, synchronous active-low reset
//   start, base_addr, count : run request, first index, element count
//   busy, done, timeout_err : run status (done is a one-cycle pulse)
//   mem_read_addr, mem_data_out : read port; data must be valid in the
//                             MEM_RD_LATENCY-th cycle the address is driven
//   mem_write_addr, mem_data_in, mem_write_en : write port
//   norm_start, norm_angle, norm_done, norm_result : normalizer handshake
//
// state  | meaning
// IDLE   | waiting for start
// READ   | address driven, waiting MEM_RD_LATENCY cycles for data
// ISSUE  | norm_start pulse with the captured angle
// WAIT   | waiting for norm_done, watchdog running
// WRITE  | write-back strobe at the current index
// FINISH | done pulse, back to IDLE
module angle_norm_sequencer
  import angle_norm_pkg::*;
#(
  parameter int EXP_LEN        = 8,
  parameter int MANTISSA_LEN   = 23,
  parameter int NUM_ANGLE      = 22,
  parameter int MEM_RD_LATENCY = 1,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int W  = word_width(EXP_LEN, MANTISSA_LEN),
  localparam int AW = addr_width(NUM_ANGLE),
  localparam int CW = count_width(NUM_ANGLE)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] count,
  output logic          busy,
  output logic          done,
  output logic          timeout_err,
  output logic [AW-1:0] mem_read_addr,
  input  logic [W-1:0]  mem_data_out,
  output logic [AW-1:0] mem_write_addr,
  output logic [W-1:0]  mem_data_in,
  output logic          mem_write_en,
  output logic          norm_start,
  output logic [W-1:0]  norm_angle,
  input  logic          norm_done,
  input  logic [W-1:0]  norm_result
);

  localparam logic [CW-1:0] DEPTH_C  = CW'(NUM_ANGLE);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_ANGLE - 1);
  localparam logic [1:0]    RD_LAST  = 2'(MEM_RD_LATENCY - 1);

  state_t        state;
  logic [AW-1:0] idx;
  logic [AW-1:0] next_idx;
  logic [AW-1:0] base_fold;
  logic [CW-1:0] remaining;
  logic [CW-1:0] req_count;
  logic [1:0]    rd_cnt;
  logic          to_expired;

  // Explicit compare-and-clear so non-power-of-two depths wrap correctly.
  assign next_idx  = (idx == LAST_IDX) ? '0 : idx + 1'b1;
  // Out-of-range base indices are folded back into the memory.
  assign base_fold = (base_addr > LAST_IDX) ? base_addr - AW'(NUM_ANGLE) : base_addr;
  assign req_count = (count > DEPTH_C) ? DEPTH_C : count;

  angle_norm_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset_n(reset_n),
    .load   (state == ST_ISSUE),
    .enable (state == ST_WAIT),
    .expired(to_expired)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      idx            <= '0;
      remaining      <= '0;
      rd_cnt         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout_err    <= 1'b0;
      mem_read_addr  <= '0;
      mem_write_addr <= '0;
      mem_data_in    <= '0;
      mem_write_en   <= 1'b0;
      norm_start     <= 1'b0;
      norm_angle     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx           <= base_fold;
            mem_read_addr <= base_fold;
            remaining     <= req_count;
            rd_cnt        <= '0;
            timeout_err   <= 1'b0;
            if (req_count == '0) begin
              done  <= 1'b1;
              state <= ST_FINISH;
            end else begin
              busy  <= 1'b1;
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (rd_cnt == RD_LAST) begin
            norm_angle <= mem_data_out;
            norm_start <= 1'b1;
            state      <= ST_ISSUE;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        ST_ISSUE: begin
          norm_start <= 1'b0;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (norm_done) begin
            mem_data_in    <= norm_result;
            mem_write_addr <= idx;
            mem_write_en   <= 1'b1;
            state          <= ST_WRITE;
          end else if (to_expired) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= ST_FINISH;
          end
        end
        ST_WRITE: begin
          mem_write_en <= 1'b0;
          remaining    <= remaining - 1'b1;
          if (remaining == CW'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_FINISH;
          end else begin
            idx           <= next_idx;
            mem_read_addr <= next_idx;
            rd_cnt        <= '0;
            state         <= ST_READ;
          end
        end
        ST_FINISH: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_angle_norm_sequencer.sv
// Self-checking bench for angle_norm_sequencer: behavioural memory and
// normalizer models, run-level expectations computed from the element count,
// base index, wrap rule and normalizer latencies.
module tb_angle_norm_sequencer;

  localparam int N  = 22;
  localparam int W  = 32;
  localparam int AW = 5;
  localparam int CW = 5;
  localparam int L  = 1;
  localparam int T  = 64;
  localparam logic [W-1:0] KEY = 32'h5A5A_C3C3;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] count;
  logic          busy;
  logic          done;
  logic          timeout_err;
  logic [AW-1:0] mem_read_addr;
  logic [W-1:0]  mem_data_out;
  logic [AW-1:0] mem_write_addr;
  logic [W-1:0]  mem_data_in;
  logic          mem_write_en;
  logic          norm_start;
  logic [W-1:0]  norm_angle;
  logic          norm_done;
  logic [W-1:0]  norm_result;

  angle_norm_sequencer #(
    .EXP_LEN(8), .MANTISSA_LEN(23), .NUM_ANGLE(N),
    .MEM_RD_LATENCY(L), .TIMEOUT_CYCLES(T)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .count(count), .busy(busy), .done(done), .timeout_err(timeout_err),
    .mem_read_addr(mem_read_addr), .mem_data_out(mem_data_out),
    .mem_write_addr(mem_write_addr), .mem_data_in(mem_data_in),
    .mem_write_en(mem_write_en), .norm_start(norm_start),
    .norm_angle(norm_angle), .norm_done(norm_done), .norm_result(norm_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Memory: contents only written by the stimulus; read data valid while the
  // address is driven (latency 1).
  logic [W-1:0] mem [N];
  assign mem_data_out = (int'(mem_read_addr) < N) ? mem[mem_read_addr] : '0;

  // Normalizer: answers `lat` cycles after norm_start with angle ^ KEY,
  // optionally never answers on one chosen start, optionally emits stray
  // norm_done pulses while idle.
  int           norm_lat = 3;
  bit           rand_lat = 0;
  bit           spur_en  = 0;
  int           hang_abs = -1;
  int           ncnt     = 0;
  int           ns_total = 0;
  int           lat_sum  = 0;
  int           cur_lat;
  logic [W-1:0] held     = '0;
  logic         spur     = 1'b0;

  always @(posedge clock) begin
    cur_lat = rand_lat ? int'($urandom_range(5, 1)) : norm_lat;
    spur <= spur_en && ($urandom_range(3, 0) == 0);
    if (!reset_n) begin
      ncnt <= 0;
    end else if (norm_start) begin
      ns_total <= ns_total + 1;
      held     <= norm_angle;
      if (ns_total == hang_abs) begin
        ncnt <= 0;
      end else begin
        ncnt    <= cur_lat;
        lat_sum <= lat_sum + cur_lat;
      end
    end else if (ncnt != 0) begin
      ncnt <= ncnt - 1;
    end
  end

  assign norm_done   = (ncnt == 1) || (spur && ncnt == 0);
  assign norm_result = held ^ KEY;

  // Monitor: monotonic event counters and a write log.
  int           cyc = 0, wr_total = 0, done_total = 0, busy_total = 0;
  int           excl_total = 0, start_cyc = 0, done_cyc = 0;
  logic [AW-1:0] wr_addr_log [4096];
  logic [W-1:0]  wr_data_log [4096];

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset_n) begin
      if (mem_write_en) begin
        wr_addr_log[wr_total[11:0]] <= mem_write_addr;
        wr_data_log[wr_total[11:0]] <= mem_data_in;
        wr_total <= wr_total + 1;
      end
      if (done) begin
        done_total <= done_total + 1;
        done_cyc   <= cyc;
      end
      if (busy) busy_total <= busy_total + 1;
      if (int'(mem_write_en) + int'(norm_start) + int'(done) > 1) excl_total <= excl_total + 1;
      if (start && !busy && !done) start_cyc <= cyc;
    end
  end

  task automatic run_case(input string name, input int base, input int cnt, input int lat,
                          input bit rl, input int hang, input bit spur_on, input int extra_at);
    int n, completed, busy_exp, wr0, d0, b0, e0, ls0, ns0, k, a;
    bit to_exp;
    for (int i = 0; i < N; i++) mem[i] = $urandom();
    norm_lat = lat;
    rand_lat = rl;
    spur_en  = spur_on;
    wr0 = wr_total; d0 = done_total; b0 = busy_total; e0 = excl_total;
    ls0 = lat_sum;  ns0 = ns_total;
    hang_abs = (hang >= 0) ? ns_total + hang : -1;
    n = (cnt > N) ? N : cnt;
    to_exp    = (hang >= 0) && (hang < n);
    completed = to_exp ? hang : n;

    @(negedge clock);
    base_addr = AW'(base);
    count     = CW'(cnt);
    start     = 1'b1;
    @(negedge clock);
    start = 1'b0;
    k = 0;
    while (done_total == d0 && k < 4000) begin
      start = (k == extra_at);
      @(negedge clock);
      k++;
    end
    start = 1'b0;
    check({name, " done_seen"}, done_total != d0, 1);
    repeat (3) @(negedge clock);
    spur_en = 0;

    busy_exp = completed * (L + 2) + (lat_sum - ls0) + (to_exp ? L + 1 + T : 0);
    check({name, " writes"}, wr_total - wr0, completed);
    check({name, " done_pulses"}, done_total - d0, 1);
    check({name, " busy_cycles"}, busy_total - b0, busy_exp);
    check({name, " done_latency"}, done_cyc - start_cyc, busy_exp + 1);
    check({name, " norm_starts"}, ns_total - ns0, completed + int'(to_exp));
    check({name, " timeout_err"}, timeout_err, to_exp);
    check({name, " exclusive"}, excl_total - e0, 0);
    check({name, " busy_after"}, busy, 0);
    for (int i = 0; i < completed; i++) begin
      a = (base + i) % N;
      check({name, " wr_addr"}, wr_addr_log[(wr0 + i) % 4096], a);
      check({name, " wr_data"}, wr_data_log[(wr0 + i) % 4096], mem[a] ^ KEY);
    end
  endtask

  task automatic reset_case();
    int wr0, d0, ns0, k;
    for (int i = 0; i < N; i++) mem[i] = $urandom();
    norm_lat = 3; rand_lat = 0; spur_en = 0; hang_abs = -1;
    wr0 = wr_total; d0 = done_total; ns0 = ns_total;
    @(negedge clock);
    base_addr = '0;
    count     = CW'(N);
    start     = 1'b1;
    @(negedge clock);
    start = 1'b0;
    k = 0;
    while (ns_total - ns0 < 5 && k < 2000) begin
      @(negedge clock);
      k++;
    end
    check("rst reached_elem4", ns_total - ns0, 5);
    check("rst writes_before", wr_total - wr0, 4);
    reset_n = 1'b0;
    @(negedge clock);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst timeout_err", timeout_err, 0);
    check("rst mem_write_en", mem_write_en, 0);
    check("rst norm_start", norm_start, 0);
    check("rst mem_read_addr", mem_read_addr, 0);
    check("rst mem_write_addr", mem_write_addr, 0);
    check("rst mem_data_in", mem_data_in, 0);
    check("rst norm_angle", norm_angle, 0);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    check("rst writes_after", wr_total - wr0, 4);
    check("rst no_done", done_total - d0, 0);
    check("rst idle_busy", busy, 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (3) @(negedge clock);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset timeout_err", timeout_err, 0);
    check("reset norm_start", norm_start, 0);
    check("reset mem_write_en", mem_write_en, 0);
    reset_n = 1'b1;
    @(negedge clock);

    run_case("full",  0, 22, 3, 0, -1, 0, -1);
    run_case("wrap", 20,  5, 3, 0, -1, 0, -1);
    run_case("zero",  7,  0, 3, 0, -1, 0, -1);
    run_case("hang",  0, 22, 3, 0,  2, 0, -1);
    run_case("clear", 3,  4, 2, 0, -1, 0, -1);
    run_case("over",  5, 30, 1, 0, -1, 0, 10);
    for (int r = 0; r < 6; r++) begin
      run_case("rand", int'($urandom_range(21, 0)), int'($urandom_range(25, 0)),
               1, 1, -1, 1, int'($urandom_range(30, 2)));
    end
    reset_case();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
